// File: rtl/present_round_ctrl.sv
// present_round_ctrl: round/key-schedule sequencer for a PRESENT datapath.
// Handles encrypt and decrypt, tracks whether the key register holds the first
// or the last round key, and inserts a key-roll phase (KEYPREP) when the key
// register is at the wrong end for the requested mode.
// Optional feature: define PRESENT_CTRL_ERR_EN to add the sticky outErr port.
module present_round_ctrl #(
    parameter int unsigned ROUNDS = 31,
    parameter int unsigned CNT_W  = 5
) (
    input  logic             inClk,
    input  logic             inRst,
    input  logic             inKeyExtWr,
    input  logic             inExtDataWr,
    input  logic             inDecrypt,
    output logic             outStateExtWr,
    output logic             outStateIntWr,
    output logic             outKeyExtWr,
    output logic             outKeyIntWr,
    output logic             outKeyInvWr,
    output logic             outDataIntWr,
    output logic [CNT_W-1:0] outRoundCounter,
    output logic             outMode,
    output logic             outBusy,
    output logic             outReady,
    output logic             outDone
`ifdef PRESENT_CTRL_ERR_EN
    ,
    output logic             outErr
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROUNDS);

    typedef enum logic [1:0] {IDLE, KEYPREP, ROUND, FINAL} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             key_at_end, key_at_end_nxt;
    logic             mode, mode_nxt;
    logic             key_at_end_eff;

    // State, counter, key position and mode registers
    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            state      <= IDLE;
            cnt        <= '0;
            key_at_end <= 1'b0;
            mode       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            key_at_end <= key_at_end_nxt;
            mode       <= mode_nxt;
        end
    end

    // Next-state, counter sequencing and datapath strobe decode
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        key_at_end_nxt = key_at_end;
        mode_nxt       = mode;
        key_at_end_eff = key_at_end;
        outStateExtWr  = 1'b0;
        outStateIntWr  = 1'b0;
        outKeyExtWr    = 1'b0;
        outKeyIntWr    = 1'b0;
        outKeyInvWr    = 1'b0;
        outDataIntWr   = 1'b0;
        outDone        = 1'b0;
        outBusy        = 1'b1;
        outReady       = 1'b0;
        case (state)
            IDLE: begin
                outBusy       = 1'b0;
                outReady      = 1'b1;
                // Host strobes pass straight through, but never while reset is held
                outKeyExtWr   = inKeyExtWr & ~inRst;
                outStateExtWr = inExtDataWr & ~inRst;
                if (inKeyExtWr) begin
                    key_at_end_nxt = 1'b0;
                    key_at_end_eff = 1'b0;
                end
                if (inExtDataWr) begin
                    mode_nxt = inDecrypt;
                    if (inDecrypt == key_at_end_eff) begin
                        state_nxt = ROUND;
                        cnt_nxt   = inDecrypt ? CNT_MAX : CNT_ONE;
                    end else begin
                        state_nxt = KEYPREP;
                        cnt_nxt   = inDecrypt ? CNT_ONE : CNT_MAX;
                    end
                end
            end
            KEYPREP: begin
                // Roll the key to the other end without touching the state
                outKeyIntWr = mode;
                outKeyInvWr = ~mode;
                if (cnt == (mode ? CNT_MAX : CNT_ONE)) begin
                    state_nxt      = ROUND;
                    key_at_end_nxt = ~key_at_end;
                    cnt_nxt        = mode ? CNT_MAX : CNT_ONE;
                end else begin
                    cnt_nxt = mode ? cnt + CNT_ONE : cnt - CNT_ONE;
                end
            end
            ROUND: begin
                outStateIntWr = 1'b1;
                outKeyIntWr   = ~mode;
                outKeyInvWr   = mode;
                if (cnt == (mode ? CNT_ONE : CNT_MAX)) begin
                    state_nxt      = FINAL;
                    key_at_end_nxt = ~mode;
                end else begin
                    cnt_nxt = mode ? cnt - CNT_ONE : cnt + CNT_ONE;
                end
            end
            FINAL: begin
                outDataIntWr = 1'b1;
                outDone      = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign outRoundCounter = cnt;
    assign outMode         = mode;

`ifdef PRESENT_CTRL_ERR_EN
    // Sticky flag for host writes attempted while an operation is running
    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            outErr <= 1'b0;
        end else if (state == IDLE) begin
            if (inKeyExtWr) outErr <= 1'b0;
        end else if (inKeyExtWr || inExtDataWr) begin
            outErr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_present_round_ctrl.sv
// Directed bench for present_round_ctrl (ROUNDS=31, CNT_W=5).
// Expected strobe patterns are hand-derived per cycle from the mode, the
// expected key position (passed as the kp flag) and the phase sequencing.
module tb_present_round_ctrl;

    localparam int unsigned R = 31;
    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         rst, key_wr, data_wr, decrypt;
    logic         st_ext, st_int, k_ext, k_int, k_inv, d_int, mode_o, busy, ready, done;
    logic [W-1:0] cnt;
`ifdef PRESENT_CTRL_ERR_EN
    logic         err;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic         exp_mode;
    logic [W-1:0] exp_cnt;

    present_round_ctrl #(.ROUNDS(R), .CNT_W(W)) dut (
        .inClk(clk), .inRst(rst), .inKeyExtWr(key_wr), .inExtDataWr(data_wr),
        .inDecrypt(decrypt), .outStateExtWr(st_ext), .outStateIntWr(st_int),
        .outKeyExtWr(k_ext), .outKeyIntWr(k_int), .outKeyInvWr(k_inv),
        .outDataIntWr(d_int), .outRoundCounter(cnt), .outMode(mode_o),
        .outBusy(busy), .outReady(ready), .outDone(done)
`ifdef PRESENT_CTRL_ERR_EN
        , .outErr(err)
`endif
    );

    always #5 clk = ~clk;

    wire [14:0] obs = {st_ext, st_int, k_ext, k_int, k_inv, d_int, busy, ready, done, mode_o, cnt};

    function automatic logic [14:0] pk(input logic se, si, ke, ki, kv, di, bz, rd, dn, md,
                                       input int c);
        return {se, si, ke, ki, kv, di, bz, rd, dn, md, W'(c)};
    endfunction

    task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk1(input string tag, input logic o, input logic e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Advance to the next cycle: inputs settle 1 unit after the edge, checks 1 unit later
    task automatic next_cycle(input logic kw, input logic dw);
        @(posedge clk);
        #1;
        key_wr  = kw;
        data_wr = dw;
        #1;
    endtask

    task automatic idle_chk(input string tag);
        next_cycle(1'b0, 1'b0);
        chk(tag, obs, pk(0, 0, 0, 0, 0, 0, 0, 1, 0, exp_mode, int'(exp_cnt)));
    endtask

    // One operation from its start cycle T through FINAL
    task automatic run_op(input string tag, input logic dec, input logic kload, input logic kp,
                          input logic hold, input int pulse_at, input int abort_at);
        @(posedge clk);
        #1;
        data_wr = 1'b1;
        key_wr  = kload;
        decrypt = dec;
        #1;
        chk({tag, "_start"}, obs, pk(1, 0, kload, 0, 0, 0, 0, 1, 0, exp_mode, int'(exp_cnt)));
        exp_mode = dec;
        if (kp) begin
            for (int i = 1; i <= int'(R); i++) begin
                next_cycle(1'b0, hold);
                chk($sformatf("%s_kp%0d", tag, i), obs,
                    pk(0, 0, 0, dec, !dec, 0, 1, 0, 0, dec, dec ? i : int'(R) + 1 - i));
            end
        end
        for (int i = 1; i <= int'(R); i++) begin
            next_cycle(i == pulse_at, hold);
            chk($sformatf("%s_rnd%0d", tag, i), obs,
                pk(0, 1, 0, !dec, dec, 0, 1, 0, 0, dec, dec ? int'(R) + 1 - i : i));
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                chk({tag, "_rst"}, obs, pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
                exp_mode = 1'b0;
                exp_cnt  = '0;
                @(posedge clk);
                #1;
                rst     = 1'b0;
                data_wr = 1'b0;
                return;
            end
        end
        next_cycle(1'b0, hold);
        chk({tag, "_final"}, obs, pk(0, 0, 0, 0, 0, 1, 1, 0, 1, dec, dec ? 1 : int'(R)));
        exp_cnt = dec ? W'(1) : W'(R);
    endtask

    initial begin
        rst      = 1'b1;
        key_wr   = 1'b1;
        data_wr  = 1'b1;
        decrypt  = 1'b1;
        exp_mode = 1'b0;
        exp_cnt  = '0;
        #2;
        chk("reset", obs, pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
`ifdef PRESENT_CTRL_ERR_EN
        chk1("reset_err", err, 1'b0);
`endif
        @(posedge clk);
        #1;
        rst     = 1'b0;
        key_wr  = 1'b0;
        data_wr = 1'b0;
        decrypt = 1'b0;

        // Key load alone passes through in IDLE
        next_cycle(1'b1, 1'b0);
        chk("key_load", obs, pk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));

        // Encrypt with key at start, then decrypt with key at end: no key roll
        run_op("enc1", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        idle_chk("enc1_idle");
        run_op("dec1", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        idle_chk("dec1_idle");

        // Fresh key then decrypt: forward key roll first
        next_cycle(1'b1, 1'b0);
        chk("key_load2", obs, pk(0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1));
        run_op("dec2", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        idle_chk("dec2_idle");

        // Start held high: back-to-back encrypts, the later two need an inverse roll
        run_op("hold1", 1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
        run_op("hold2", 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        run_op("hold3", 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        idle_chk("hold_idle");

        // Key and start together with key at end: decrypt must roll
        run_op("both", 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        idle_chk("both_idle");

        // Key strobe mid-operation is ignored; key stays at end afterwards
        run_op("busykey", 1'b0, 1'b0, 1'b0, 1'b0, 5, 0);
        idle_chk("busykey_idle");
`ifdef PRESENT_CTRL_ERR_EN
        chk1("err_set", err, 1'b1);
`endif
        run_op("nokey", 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        idle_chk("nokey_idle");
        next_cycle(1'b1, 1'b0);
        chk("key_load3", obs, pk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, int'(R)));
`ifdef PRESENT_CTRL_ERR_EN
        idle_chk("err_clr_idle");
        chk1("err_clr", err, 1'b0);
`endif

        // Reset during ROUND at counter 12, then a plain encrypt
        run_op("rstop", 1'b0, 1'b1, 1'b0, 1'b0, 0, 12);
        run_op("post", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        idle_chk("post_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
